// File: rtl/cache_pkg.sv
// Shared types for the cacheline arbiter slice: bus widths, requester ids and
// the read-tracking entry layout.
package cache_pkg;
  localparam int CACHELINE_BITS = 256;
  localparam int ADDR_BITS      = 32;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_e;

  typedef struct packed {
    logic                 valid;
    logic [ADDR_BITS-1:0] addr;
    req_id_e              owner;
  } trk_entry_t;
endpackage

// File: rtl/cacheline_itf.sv
// Cacheline request/response port. master issues read/write, slave answers
// with ready and out-of-order rvalid tagged by raddr.
interface cacheline_itf;
  import cache_pkg::*;

  logic [ADDR_BITS-1:0]      addr;
  logic                      read;
  logic                      write;
  logic [CACHELINE_BITS-1:0] wdata;
  logic                      ready;
  logic                      rvalid;
  logic [CACHELINE_BITS-1:0] rdata;
  logic [ADDR_BITS-1:0]      raddr;

  modport master (
    output addr, read, write, wdata,
    input  ready, rvalid, rdata, raddr
  );

  modport slave (
    input  addr, read, write, wdata,
    output ready, rvalid, rdata, raddr
  );
endinterface

// File: rtl/cacheline_rd_tracker.sv
// Table of reads in flight downstream: allocates the lowest free slot,
// CAM-matches returning raddr, and reports fullness / per-requester addr hits.
module cacheline_rd_tracker
  import cache_pkg::*;
#(
  parameter  int OUTSTANDING = 4,
  parameter  int NQ          = 2,
  localparam int IDX_W       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_en,
  input  logic [ADDR_BITS-1:0]         alloc_addr,
  input  req_id_e                      alloc_owner,
  input  logic                         lk_en,
  input  logic [ADDR_BITS-1:0]         lk_addr,
  output logic                         lk_hit,
  output req_id_e                      lk_owner,
  output logic [IDX_W-1:0]             lk_idx,
  input  logic [NQ-1:0][ADDR_BITS-1:0] q_addr,
  output logic [NQ-1:0]                q_match,
  output logic                         full,
  output logic                         busy
);
  trk_entry_t [OUTSTANDING-1:0] tbl;
  logic [OUTSTANDING-1:0] vld, hit_vec, alloc_oh;

  always_comb begin
    for (int e = 0; e < OUTSTANDING; e++) begin
      vld[e]     = tbl[e].valid;
      hit_vec[e] = lk_en && tbl[e].valid && (tbl[e].addr == lk_addr);
    end
  end

  // Lowest free slot as a one-hot; only used when the table is not full.
  assign alloc_oh = ~vld & (vld + OUTSTANDING'(1));
  assign full     = &vld;
  assign busy     = |vld;

  always_comb begin
    lk_hit   = 1'b0;
    lk_owner = REQ_ICACHE;
    lk_idx   = '0;
    for (int e = 0; e < OUTSTANDING; e++) begin
      if (hit_vec[e]) begin
        lk_hit   = 1'b1;
        lk_owner = tbl[e].owner;
        lk_idx   = IDX_W'(e);
      end
    end
  end

  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      q_match[q] = 1'b0;
      for (int e = 0; e < OUTSTANDING; e++)
        if (tbl[e].valid && (tbl[e].addr == q_addr[q])) q_match[q] = 1'b1;
    end
  end

  // Freed and allocated slots can never coincide: allocation only targets
  // slots that are already invalid in the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl <= '0;
    end else begin
      for (int e = 0; e < OUTSTANDING; e++) begin
        if (alloc_en && alloc_oh[e])
          tbl[e] <= '{valid: 1'b1, addr: alloc_addr, owner: alloc_owner};
        else if (hit_vec[e])
          tbl[e].valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline memory port between icache and dcache: round-robin
// grant held until accepted, reads tracked by address for response routing.
module cacheline_arbiter
  import cache_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cacheline_itf.slave  icache,
  cacheline_itf.slave  dcache,
  cacheline_itf.master mem,
  output logic         resp_err,
  output logic         busy
);
  localparam int NREQ  = 2;
  localparam int IDX_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic [NREQ-1:0]                     rq_rd, rq_wr, req, elig, rq_rdy, q_match;
  logic [NREQ-1:0][ADDR_BITS-1:0]      rq_addr;
  logic [NREQ-1:0][CACHELINE_BITS-1:0] rq_wdata;

  logic             full, lk_hit, gnt_vld, accept, lock_vld, lock_eff;
  req_id_e          lk_owner, lock_id, rr_ptr, gnt_id;
  logic [IDX_W-1:0] lk_idx;

  assign rq_rd    = {dcache.read,  icache.read};
  assign rq_wr    = {dcache.write, icache.write};
  assign rq_addr  = {dcache.addr,  icache.addr};
  assign rq_wdata = {dcache.wdata, icache.wdata};

  // A read waits while the table is full or its line is already in flight.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      req[r]  = rq_rd[r] | rq_wr[r];
      elig[r] = req[r] & ~(rq_rd[r] & (full | q_match[r]));
    end
  end

  // A locked requester that withdraws loses the lock immediately.
  assign lock_eff = lock_vld & req[lock_id];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_ptr;
    if (lock_eff) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id;
    end else if (elig[0] && elig[1]) begin
      gnt_vld = 1'b1;
      gnt_id  = rr_ptr;
    end else if (elig[0]) begin
      gnt_vld = 1'b1;
      gnt_id  = REQ_ICACHE;
    end else if (elig[1]) begin
      gnt_vld = 1'b1;
      gnt_id  = REQ_DCACHE;
    end
    gnt_vld = gnt_vld & rst_n;
  end

  assign mem.read  = gnt_vld & rq_rd[gnt_id];
  assign mem.write = gnt_vld & rq_wr[gnt_id];
  assign mem.addr  = gnt_vld ? rq_addr[gnt_id]  : '0;
  assign mem.wdata = gnt_vld ? rq_wdata[gnt_id] : '0;

  assign accept    = gnt_vld & mem.ready;
  assign rq_rdy[0] = accept & (gnt_id == REQ_ICACHE);
  assign rq_rdy[1] = accept & (gnt_id == REQ_DCACHE);

  assign icache.ready  = rq_rdy[0];
  assign dcache.ready  = rq_rdy[1];
  assign icache.rvalid = lk_hit & (lk_owner == REQ_ICACHE);
  assign dcache.rvalid = lk_hit & (lk_owner == REQ_DCACHE);
  assign icache.rdata  = mem.rdata;
  assign dcache.rdata  = mem.rdata;
  assign icache.raddr  = mem.raddr;
  assign dcache.raddr  = mem.raddr;

  // read|write together is tracked as a read so its response still routes.
  cacheline_rd_tracker #(
    .OUTSTANDING (OUTSTANDING),
    .NQ          (NREQ)
  ) u_trk (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_en    (accept & rq_rd[gnt_id]),
    .alloc_addr  (rq_addr[gnt_id]),
    .alloc_owner (gnt_id),
    .lk_en       (mem.rvalid),
    .lk_addr     (mem.raddr),
    .lk_hit      (lk_hit),
    .lk_owner    (lk_owner),
    .lk_idx      (lk_idx),
    .q_addr      (rq_addr),
    .q_match     (q_match),
    .full        (full),
    .busy        (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_id  <= REQ_ICACHE;
      rr_ptr   <= REQ_DCACHE;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        lock_vld <= 1'b0;
        rr_ptr   <= (gnt_id == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
      end else if (gnt_vld) begin
        lock_vld <= 1'b1;
        lock_id  <= gnt_id;
      end else begin
        lock_vld <= 1'b0;
      end
      if (mem.rvalid && !lk_hit) resp_err <= 1'b1;
    end
  end

  for (genvar r = 0; r < NREQ; r++) begin : g_chk
    a_rw_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(rq_rd[r] && rq_wr[r]));
    a_req_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (req[r] && !rq_rdy[r]) |=> req[r]);
  end

  a_idx_range : assert property (@(posedge clk) disable iff (!rst_n)
    lk_hit |-> (int'(lk_idx) < OUTSTANDING));
endmodule
